// File: rtl/sum_uart_pkg.sv
// Shared definitions for the sum UART transmitter: FSM state encoding and frame constants.
package sum_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sum_fifo.sv
// Synchronous byte FIFO; full/empty come from the occupancy counter, pointers wrap naturally.
module sum_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               din_i,
    output logic [7:0]               dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok_s, pop_ok_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign dout_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Storage array: written at the tail on an accepted push; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sum_uart_tx.sv
// Buffers adder sums and sends each one as a UART 8N1 frame, LSB first.
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [7:0]                    sum_in,
    input  logic                          sum_valid,
    output logic                          sum_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int             BW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [2:0]     BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_e    state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           overflow_q;
    logic           pop_s, bit_end_s, start_ok_s;
    logic           fifo_full_s, fifo_empty_s;
    logic [7:0]     fifo_dout_s;

    sum_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (sum_valid),
        .pop_i   (pop_s),
        .din_i   (sum_in),
        .dout_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count)
    );

    assign sum_ready  = !fifo_full_s;
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign overflow   = overflow_q;
    assign bit_end_s  = (baud_q == BAUD_LAST);
    assign start_ok_s = !fifo_empty_s && ena;

    // Next-state logic: frame sequencing, baud counting, bit shifting and the next line level.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (start_ok_s) begin
                    state_d = START;
                    pop_s   = 1'b1;
                    shift_d = fifo_dout_s;
                    tx_d    = 1'b0;
                end else begin
                    tx_d    = UART_IDLE_LEVEL;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end else begin
                    baud_d  = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        tx_d    = UART_IDLE_LEVEL;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    baud_d = '0;
                    if (start_ok_s) begin
                        state_d = START;
                        pop_s   = 1'b1;
                        shift_d = fifo_dout_s;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = UART_IDLE_LEVEL;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = UART_IDLE_LEVEL;
            end
        endcase
    end

    // Transmitter state registers; reset forces the line idle and abandons any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= UART_IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Sticky overflow: a valid byte offered while the buffer is full is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_q | (sum_valid & fifo_full_s);
        end
    end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Self-checking bench for sum_uart_tx: vector table of frames, scoreboarded UART decoder, corner sequences.
module tb_sum_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int FRAME   = 10 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       sum_valid = 1'b0;
    logic [7:0] sum_in = 8'h00;
    logic       sum_ready, tx, busy, overflow;
    logic [2:0] fifo_count;

    sum_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .sum_in     (sum_in),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int frames_rx = 0;
    logic [7:0] exp_q[$];
    int start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        sum_in    = d;
        sum_valid = 1'b1;
        step();
        sum_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t;
        t = 0;
        while (frames_rx < n && t < budget) begin
            step();
            t++;
        end
        chk("frames_done", 32'(frames_rx), 32'(n));
    endtask

    // UART decoder: samples mid-bit on the falling edge and scores each byte against the queue.
    initial begin : monitor
        bit         active;
        int         cnt;
        logic [7:0] b;
        logic [7:0] e;
        active = 1'b0;
        cnt    = 0;
        b      = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    cnt    = 0;
                    b      = 8'h00;
                    start_q.push_back(cyc);
                end
            end else begin
                cnt++;
                if (cnt >= 6 && cnt <= 34 && (cnt % CLK_DIV) == 2) b = {tx, b[7:1]};
                if (cnt == 38) chk("stop_bit", 32'(tx), 32'd1);
                if (cnt == FRAME - 1) begin
                    active = 1'b0;
                    frames_rx++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame actual=%0h required=none", b);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_byte", 32'(b), 32'(e));
                    end
                end
            end
        end
    end

    typedef struct {
        logic [7:0] din;
        logic [9:0] line;   // bit 0 = start bit, bits 1..8 = data LSB first, bit 9 = stop
    } vec_t;

    vec_t vecs[5];

    initial begin : main
        int         busy_n, t, bs, fr0;
        logic [9:0] line_s;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h81, 10'b1100000010};

        // Reset and idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle_tx", 32'(tx), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_ready", 32'(sum_ready), 32'd1);
            chk("idle_count", 32'(fifo_count), 32'd0);
            chk("idle_ovf", 32'(overflow), 32'd0);
        end

        // Table-driven single frames
        ena = 1'b1;
        for (int v = 0; v < 5; v++) begin
            exp_q.push_back(vecs[v].din);
            push_byte(vecs[v].din);
            chk("no_early_start", 32'(tx), 32'd1);
            chk("count_after_push", 32'(fifo_count), 32'd1);
            line_s = vecs[v].line;
            busy_n = 0;
            for (int k = 1; k <= FRAME + 1; k++) begin
                step();
                if (busy) busy_n++;
                if (k == 1) chk("latency_start", 32'(tx), 32'd0);
                if (k <= FRAME && ((k - 1) % CLK_DIV) == 2) begin
                    chk($sformatf("vec%0d_bit%0d", v, (k - 1) / CLK_DIV), 32'(tx), 32'(line_s[0]));
                    line_s = line_s >> 1;
                end
            end
            chk("busy_cycles", 32'(busy_n), 32'(FRAME));
            chk("idle_after_frame", 32'(busy), 32'd0);
        end

        // Burst of five plus one overflowing byte
        bs = start_q.size();
        fr0 = frames_rx;
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        sum_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            sum_in = 8'(i);
            step();
        end
        chk("burst_count_full", 32'(fifo_count), 32'd4);
        chk("burst_ready_low", 32'(sum_ready), 32'd0);
        chk("burst_no_ovf_yet", 32'(overflow), 32'd0);
        sum_in = 8'h06;
        step();
        sum_valid = 1'b0;
        chk("burst_ovf_set", 32'(overflow), 32'd1);
        chk("burst_count_hold", 32'(fifo_count), 32'd4);
        wait_frames(fr0 + 5, 5 * FRAME + 20);
        if (start_q.size() >= bs + 5) begin
            for (int i = 1; i < 5; i++)
                chk("burst_gap", 32'(start_q[bs + i] - start_q[bs + i - 1]), 32'(FRAME));
        end else begin
            checks++;
            failures++;
            $display("FAIL burst_starts actual=%0d required=%0d", start_q.size() - bs, 5);
        end
        step();
        chk("burst_drained", 32'(fifo_count), 32'd0);

        // ena gating
        ena = 1'b0;
        fr0 = frames_rx;
        exp_q.push_back(8'h3C);
        push_byte(8'h3C);
        repeat (20) step();
        chk("gate_tx_idle", 32'(tx), 32'd1);
        chk("gate_busy_low", 32'(busy), 32'd0);
        chk("gate_count1", 32'(fifo_count), 32'd1);
        exp_q.push_back(8'h5A);
        push_byte(8'h5A);
        chk("gate_count2", 32'(fifo_count), 32'd2);
        ena = 1'b1;
        step();
        chk("gate_start_tx", 32'(tx), 32'd0);
        chk("gate_start_busy", 32'(busy), 32'd1);
        chk("gate_popped", 32'(fifo_count), 32'd1);
        repeat (10) step();
        ena = 1'b0;
        t = 0;
        while (busy && t < FRAME + 10) begin
            step();
            t++;
        end
        chk("gate_frame_done", 32'(busy), 32'd0);
        repeat (30) step();
        chk("gate_held_busy", 32'(busy), 32'd0);
        chk("gate_held_tx", 32'(tx), 32'd1);
        chk("gate_held_count", 32'(fifo_count), 32'd1);
        chk("gate_one_frame", 32'(frames_rx), 32'(fr0 + 1));
        ena = 1'b1;
        wait_frames(fr0 + 2, FRAME + 20);

        // Reset during DATA bit 3 with two bytes queued
        fr0 = frames_rx;
        sum_valid = 1'b1;
        sum_in = 8'h11;
        step();
        sum_in = 8'h22;
        step();
        sum_in = 8'h33;
        step();
        sum_valid = 1'b0;
        chk("rst_queued", 32'(fifo_count), 32'd2);
        repeat (16) step();
        chk("rst_busy_before", 32'(busy), 32'd1);
        chk("rst_ovf_before", 32'(overflow), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx_async", 32'(tx), 32'd1);
        chk("rst_busy_async", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        chk("rst_count_clear", 32'(fifo_count), 32'd0);
        chk("rst_ovf_clear", 32'(overflow), 32'd0);
        chk("rst_ready", 32'(sum_ready), 32'd1);
        for (int i = 0; i < 60; i++) begin
            step();
            chk("rst_quiet_tx", 32'(tx), 32'd1);
            chk("rst_quiet_busy", 32'(busy), 32'd0);
        end
        chk("rst_no_frame", 32'(frames_rx), 32'(fr0));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
